// File: rtl/div_ramp_ctrl.sv
// div_ramp_ctrl: sequencer for the motor-clock frequency divider.
// Accepts a target divide constant over valid/ready, then ramps div_const
// toward it one STEP per RAMP_TICKS cycles (soft start / soft stop) and holds.
// A target of 0 requests a controlled stop, and estop forces an immediate stop.
module div_ramp_ctrl #(
    parameter int DIV_MIN    = 4,
    parameter int DIV_MAX    = 4094,
    parameter int STEP       = 8,
    parameter int RAMP_TICKS = 100000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        estop,
    input  logic        cmd_valid,
    input  logic [11:0] cmd_div,
    output logic        cmd_ready,
    output logic [11:0] div_const,
    output logic        div_run,
    output logic        busy,
    output logic        at_target
);

    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_RAMP,
        ST_HOLD,
        ST_STOPPING
    } state_t;

    localparam int              PW      = $clog2(RAMP_TICKS);
    localparam logic [PW-1:0]   PS_LAST = PW'(RAMP_TICKS - 1);
    localparam logic [11:0]     DMIN    = 12'(DIV_MIN);
    localparam logic [11:0]     DMAX    = 12'(DIV_MAX);
    localparam logic [12:0]     STEP13  = 13'(STEP);

    state_t        state_reg, state_next;
    logic [11:0]   target_reg, target_next;
    logic [11:0]   div_const_reg, div_const_next;
    logic          div_run_reg, div_run_next;
    logic          busy_reg, busy_next;
    logic          at_target_reg, at_target_next;
    logic [PW-1:0] presc_reg, presc_next;

    logic          accept;
    logic          strobe;
    logic [11:0]   clamped;
    logic [11:0]   norm_target;
    logic [11:0]   step_val;

    // Commands are only taken while idle or holding; estop blocks them outright.
    assign cmd_ready = ~estop & ((state_reg == ST_STOPPED) | (state_reg == ST_HOLD));
    assign accept    = cmd_valid & cmd_ready;
    assign strobe    = (presc_reg == PS_LAST);

    assign div_const = div_const_reg;
    assign div_run   = div_run_reg;
    assign busy      = busy_reg;
    assign at_target = at_target_reg;

    // Clamp a nonzero command into the legal range and force it even (the divider halves it).
    always_comb begin
        clamped = cmd_div;
        if (cmd_div < DMIN) begin
            clamped = DMIN;
        end else if (cmd_div > DMAX) begin
            clamped = DMAX;
        end
        norm_target = {clamped[11:1], 1'b0};
    end

    // One ramp step toward the target in 13-bit arithmetic, saturating at the target.
    always_comb begin
        step_val = target_reg;
        if (div_const_reg > target_reg) begin
            if ({1'b0, div_const_reg} > ({1'b0, target_reg} + STEP13)) begin
                step_val = 12'({1'b0, div_const_reg} - STEP13);
            end
        end else begin
            if (({1'b0, div_const_reg} + STEP13) < {1'b0, target_reg}) begin
                step_val = 12'({1'b0, div_const_reg} + STEP13);
            end
        end
    end

    // Next-state, ramp and prescaler logic; estop overrides everything.
    always_comb begin
        state_next     = state_reg;
        target_next    = target_reg;
        div_const_next = div_const_reg;
        div_run_next   = div_run_reg;
        presc_next     = presc_reg;

        if (estop) begin
            state_next     = ST_STOPPED;
            target_next    = DMAX;
            div_const_next = DMAX;
            div_run_next   = 1'b0;
            presc_next     = '0;
        end else begin
            case (state_reg)
                ST_STOPPED: begin
                    presc_next = '0;
                    if (accept && (cmd_div != 12'd0)) begin
                        state_next     = ST_RAMP;
                        target_next    = norm_target;
                        div_const_next = DMAX;
                        div_run_next   = 1'b1;
                    end
                end
                ST_HOLD: begin
                    presc_next = '0;
                    if (accept) begin
                        if (cmd_div != 12'd0) begin
                            state_next  = ST_RAMP;
                            target_next = norm_target;
                        end else begin
                            state_next  = ST_STOPPING;
                            target_next = DMAX;
                        end
                    end
                end
                default: begin
                    // RAMP and STOPPING share the stepping machinery.
                    if (div_const_reg == target_reg) begin
                        presc_next = '0;
                        if (state_reg == ST_RAMP) begin
                            state_next = ST_HOLD;
                        end else begin
                            state_next   = ST_STOPPED;
                            div_run_next = 1'b0;
                        end
                    end else if (strobe) begin
                        presc_next     = '0;
                        div_const_next = step_val;
                    end else begin
                        presc_next = presc_reg + 1'b1;
                    end
                end
            endcase
        end

        busy_next      = (state_next == ST_RAMP) || (state_next == ST_STOPPING);
        at_target_next = (state_next == ST_HOLD);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_STOPPED;
            target_reg    <= DMAX;
            div_const_reg <= DMAX;
            div_run_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            at_target_reg <= 1'b0;
            presc_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            target_reg    <= target_next;
            div_const_reg <= div_const_next;
            div_run_reg   <= div_run_next;
            busy_reg      <= busy_next;
            at_target_reg <= at_target_next;
            presc_reg     <= presc_next;
        end
    end

endmodule

// File: tb/tb_div_ramp_ctrl.sv
// tb_div_ramp_ctrl: directed test of the divider ramp controller with
// small parameters (DIV_MIN=4, DIV_MAX=64, STEP=8, RAMP_TICKS=4).
module tb_div_ramp_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        estop;
    logic        cmd_valid;
    logic [11:0] cmd_div;
    logic        cmd_ready;
    logic [11:0] div_const;
    logic        div_run;
    logic        busy;
    logic        at_target;

    int total = 0;
    int bad   = 0;

    div_ramp_ctrl #(
        .DIV_MIN    (4),
        .DIV_MAX    (64),
        .STEP       (8),
        .RAMP_TICKS (4)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .estop     (estop),
        .cmd_valid (cmd_valid),
        .cmd_div   (cmd_div),
        .cmd_ready (cmd_ready),
        .div_const (div_const),
        .div_run   (div_run),
        .busy      (busy),
        .at_target (at_target)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance n clock edges, then settle 1 ns past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Present a command and hold it until the edge where it is accepted.
    task automatic send_cmd(input logic [11:0] v);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_div   = v;
        while (!cmd_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) check_val("accept_timeout", 32'(n), 0);
        tick(1);
        cmd_valid = 1'b0;
    endtask

    // Wait for HOLD with a cycle budget.
    task automatic wait_hold(input string tag);
        int n;
        n = 0;
        while (!at_target && n < 500) begin
            tick(1);
            n++;
        end
        check_val(tag, 32'(at_target), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        estop     = 1'b0;
        cmd_valid = 1'b0;
        cmd_div   = 12'd0;

        // Reset values
        #12;
        check_val("rst_div_const", 32'(div_const), 64);
        check_val("rst_div_run",   32'(div_run),   0);
        check_val("rst_cmd_ready", 32'(cmd_ready), 1);
        check_val("rst_busy",      32'(busy),      0);
        check_val("rst_at_target", 32'(at_target), 0);
        rst_n = 1'b1;
        tick(2);

        // Controlled-stop command while stopped: accepted, nothing moves
        send_cmd(12'd0);
        check_val("stop_cmd_run",  32'(div_run), 0);
        check_val("stop_cmd_busy", 32'(busy),    0);

        // Start from STOPPED to 40
        send_cmd(12'd40);
        check_val("start_run",   32'(div_run),   1);
        check_val("start_const", 32'(div_const), 64);
        check_val("start_busy",  32'(busy),      1);
        check_val("start_ready", 32'(cmd_ready), 0);
        tick(3);
        check_val("start_pre_step", 32'(div_const), 64);
        tick(1);
        check_val("start_step1", 32'(div_const), 56);
        tick(4);
        check_val("start_step2", 32'(div_const), 48);
        tick(4);
        check_val("start_step3",  32'(div_const), 40);
        check_val("start_nohold", 32'(at_target), 0);
        tick(1);
        check_val("start_hold",      32'(at_target), 1);
        check_val("start_hold_busy", 32'(busy),      0);
        check_val("start_hold_rdy",  32'(cmd_ready), 1);

        // Same target again: one cycle of RAMP then HOLD
        send_cmd(12'd40);
        check_val("same_busy", 32'(busy), 1);
        tick(1);
        check_val("same_hold",  32'(at_target), 1);
        check_val("same_const", 32'(div_const), 40);

        // 40 -> 22 with partial last step; a second command waits while busy
        send_cmd(12'd22);
        cmd_valid = 1'b1;
        cmd_div   = 12'd30;
        check_val("busy_ready0", 32'(cmd_ready), 0);
        tick(4);
        check_val("dn_step1", 32'(div_const), 32);
        tick(4);
        check_val("dn_step2", 32'(div_const), 24);
        check_val("busy_ready1", 32'(cmd_ready), 0);
        tick(4);
        check_val("dn_step3", 32'(div_const), 22);
        tick(1);
        check_val("dn_hold",   32'(at_target), 1);
        check_val("dn_ready",  32'(cmd_ready), 1);
        tick(1);
        cmd_valid = 1'b0;
        check_val("held_cmd_taken", 32'(busy),      1);
        check_val("held_cmd_const", 32'(div_const), 22);
        tick(4);
        check_val("up_to_30", 32'(div_const), 30);
        tick(1);
        check_val("up_hold30", 32'(at_target), 1);

        // Clamp / normalisation
        send_cmd(12'd41);
        wait_hold("clamp41_hold");
        check_val("clamp41_const", 32'(div_const), 40);
        send_cmd(12'd3);
        wait_hold("clamp3_hold");
        check_val("clamp3_const", 32'(div_const), 4);
        send_cmd(12'd4095);
        wait_hold("clamp4095_hold");
        check_val("clamp4095_const", 32'(div_const), 64);
        check_val("clamp4095_run",   32'(div_run),   1);

        // HOLD at 48, then controlled stop
        send_cmd(12'd48);
        wait_hold("hold48");
        check_val("hold48_const", 32'(div_const), 48);
        send_cmd(12'd0);
        check_val("stopping_busy", 32'(busy), 1);
        tick(4);
        check_val("stopping_56", 32'(div_const), 56);
        tick(4);
        check_val("stopping_64",  32'(div_const), 64);
        check_val("stopping_run", 32'(div_run),   1);
        tick(1);
        check_val("stopped_run",   32'(div_run),   0);
        check_val("stopped_busy",  32'(busy),      0);
        check_val("stopped_ready", 32'(cmd_ready), 1);
        check_val("stopped_hold",  32'(at_target), 0);

        // estop mid-ramp at 48 with a command pending
        send_cmd(12'd40);
        tick(8);
        check_val("es_pre_const", 32'(div_const), 48);
        estop     = 1'b1;
        cmd_valid = 1'b1;
        cmd_div   = 12'd20;
        #1;
        check_val("es_ready0", 32'(cmd_ready), 0);
        tick(1);
        check_val("es_run",   32'(div_run),   0);
        check_val("es_const", 32'(div_const), 64);
        check_val("es_busy",  32'(busy),      0);
        tick(2);
        check_val("es_held_run", 32'(div_run), 0);
        estop     = 1'b0;
        cmd_valid = 1'b0;
        tick(1);
        check_val("es_release_ready", 32'(cmd_ready), 1);
        check_val("es_release_run",   32'(div_run),   0);

        // Asynchronous reset mid-ramp
        send_cmd(12'd40);
        tick(5);
        check_val("ar_pre_const", 32'(div_const), 56);
        rst_n = 1'b0;
        #1;
        check_val("ar_const", 32'(div_const), 64);
        check_val("ar_run",   32'(div_run),   0);
        check_val("ar_busy",  32'(busy),      0);
        #2;
        rst_n = 1'b1;
        tick(8);
        check_val("ar_no_resume_const", 32'(div_const), 64);
        check_val("ar_no_resume_run",   32'(div_run),   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
